cm_mul_scheduler: RTL and testbench



---
 rtl/cms_pkg.sv | 13 +
 rtl/cm_mul_scheduler_rr_arbiter.sv | 20 ++
 rtl/cm_mul_scheduler.sv | 99 +++++++++
 tb/tb_cm_mul_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cms_pkg.sv
// cms_pkg: FSM state encoding and multiplier mode constants for cm_mul_scheduler
package cms_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } cms_state_e;
  localparam logic [1:0] CM_8   = 2'b00;
  localparam logic [1:0] CM_2X8 = 2'b01;
  localparam logic [1:0] CM_16  = 2'b10;
  localparam logic [1:0] CM_ILL = 2'b11;
endpackage

// File: rtl/cm_mul_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid requester at or above ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  assign any = |req;
  // walk the rotated order from farthest to nearest so the nearest valid requester wins
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      idx = req[(int'(ptr) + i) % NUM_REQ] ? ID_W'((int'(ptr) + i) % NUM_REQ) : idx;
    gnt = any ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/cm_mul_scheduler.sv
// cm_mul_scheduler: round-robin sharing of one multiplier; CMS_TIMEOUT_EN adds an ISSUE watchdog
module cm_mul_scheduler
  import cms_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*16-1:0] req_a_i,
  input  logic [NUM_REQ*16-1:0] req_b_i,
  input  logic [NUM_REQ*2-1:0]  req_cm_i,
  output logic                  mul_enable_o,
  output logic [1:0]            mul_cm_o,
  output logic [15:0]           mul_a_o,
  output logic [15:0]           mul_b_o,
  input  logic [31:0]           mul_product_i,
  input  logic                  mul_valid_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_data_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);
  cms_state_e state, state_nxt;
  logic [ID_W-1:0] ptr, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic any, timeout, accept, finish;
  logic [1:0] sel_cm;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid_i),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(any)
  );
  assign sel_cm       = req_cm_i[2*int'(gidx) +: 2];
  assign accept       = state == IDLE && any;
  assign finish       = state == ISSUE && (mul_valid_i || timeout);
  assign busy_o       = state != IDLE;
  assign mul_enable_o = state == ISSUE;
  assign rsp_valid_o  = state == RESP;
`ifdef CMS_TIMEOUT_EN
  logic [31:0] to_cnt;
  // count consecutive ISSUE cycles; held at zero elsewhere so each operation starts fresh
  always_ff @(posedge clk_i) begin
    if (reset_i || state != ISSUE) to_cnt <= '0;
    else to_cnt <= to_cnt + 32'd1;
  end
  assign timeout = state == ISSUE && !mul_valid_i && to_cnt == 32'(TIMEOUT_CYC - 1);
`else
  assign timeout = TIMEOUT_CYC < 0;
`endif
  // state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= IDLE;
    else state <= state_nxt;
  end
  // next state: illegal mode skips the multiplier and needs no RECOVER, stale valids are drained in RECOVER
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (any ? (sel_cm == CM_ILL ? RESP : ISSUE) : IDLE) :
                state == ISSUE ? ((mul_valid_i || timeout) ? RESP : ISSUE) :
                state == RESP  ? (rsp_ready_i ? (mul_cm_o == CM_ILL ? IDLE : RECOVER) : RESP) :
                                 (mul_valid_i ? RECOVER : IDLE);
  end
  // accept pulse, operand/mode latches, pointer advance and response capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_ready_o <= '0;
      ptr         <= '0;
      mul_cm_o    <= '0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      req_ready_o <= accept ? gnt : '0;
      if (accept) begin
        mul_a_o    <= req_a_i[16*int'(gidx) +: 16];
        mul_b_o    <= req_b_i[16*int'(gidx) +: 16];
        mul_cm_o   <= sel_cm;
        rsp_id_o   <= gidx;
        rsp_err_o  <= sel_cm == CM_ILL;
        rsp_data_o <= '0;
        ptr        <= int'(gidx) == NUM_REQ - 1 ? '0 : gidx + ID_W'(1);
      end
      if (finish) begin
        rsp_data_o <= mul_valid_i ? mul_product_i : '0;
        rsp_err_o  <= !mul_valid_i;
      end
    end
  end
endmodule

// File: tb/tb_cm_mul_scheduler.sv
// tb_cm_mul_scheduler: randomized and directed checks of cm_mul_scheduler against a transaction model
module tb_cm_mul_scheduler;
  localparam int NR = 4;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  cm;
    int          id;
    logic [31:0] d;
    logic        e;
  } op_t;
  logic clk = 0;
  logic reset_i = 1;
  logic [NR-1:0] req_valid_i = '0;
  logic [NR-1:0] req_ready_o;
  logic [NR*16-1:0] req_a_i = '0, req_b_i = '0;
  logic [NR*2-1:0] req_cm_i = '0;
  logic mul_enable_o, mul_valid_i, rsp_valid_o, rsp_err_o, busy_o;
  logic rsp_ready_i = 1;
  logic [1:0] mul_cm_o, rsp_id_o;
  logic [15:0] mul_a_o, mul_b_o;
  logic [31:0] mul_product_i, rsp_data_o;
  int n_pass = 0, n_total = 0;
  int mode = 0;
  bit stall_mul = 0;
  op_t q[$];
  int glog[$];
  int n_rsp = 0, en_cycles = 0;
  logic [31:0] last_d;
  int last_id;
  logic last_e;
  int exp_order[5] = '{0, 1, 2, 3, 0};

  cm_mul_scheduler #(.NUM_REQ(NR), .ID_W(2), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .req_cm_i(req_cm_i),
    .mul_enable_o(mul_enable_o), .mul_cm_o(mul_cm_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_product_i(mul_product_i), .mul_valid_i(mul_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mul_ref(logic [15:0] a, logic [15:0] b, logic [1:0] cm);
    int p;
    logic [15:0] hi, lo;
    if (cm == 2'b00) begin
      p = $signed(a[7:0]) * $signed(b[7:0]);
      return p;
    end
    if (cm == 2'b01) begin
      hi = a[15:8] * b[15:8];
      lo = a[7:0] * b[7:0];
      return {hi, lo};
    end
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  function automatic int rr_pick(logic [NR-1:0] v, int p);
    for (int i = 0; i < NR; i++)
      if (v[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // multiplier stand-in: random latency (mode 10 slower), valid lingers a little after enable drops
  initial begin
    int cnt, lat, linger;
    cnt = 0; lat = 1; linger = 0;
    mul_valid_i = 0;
    mul_product_i = '0;
    forever begin
      @(posedge clk); #1;
      if (reset_i) begin
        cnt = 0;
        mul_valid_i = 0;
      end else if (mul_enable_o && !stall_mul) begin
        if (!mul_valid_i) begin
          if (cnt == 0) lat = (mul_cm_o == 2'b10) ? $urandom_range(3, 9) : $urandom_range(1, 4);
          cnt++;
          if (cnt >= lat) begin
            mul_valid_i = 1;
            mul_product_i = mul_ref(mul_a_o, mul_b_o, mul_cm_o);
          end
        end
      end else begin
        cnt = 0;
        if (mul_valid_i) begin
          if (linger == 0) begin
            mul_valid_i = 0;
            mul_product_i = $urandom;
            linger = $urandom_range(0, 2);
          end else linger--;
        end
      end
    end
  end

  // compare process: transaction model fed from what requesters presented at each accept edge
  initial begin
    logic prev_rst;
    logic [NR-1:0] snap_v;
    logic [NR*16-1:0] snap_a, snap_b;
    logic [NR*2-1:0] snap_cm;
    int mptr, g;
    op_t o;
    prev_rst = 1; mptr = 0; snap_v = '0; snap_a = '0; snap_b = '0; snap_cm = '0;
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        q.delete();
        mptr = 0;
      end else begin
        if (req_ready_o != '0) begin
          g = rr_pick(snap_v, mptr);
          chk("grant", 32'(req_ready_o), g < 0 ? 32'd0 : 32'd1 << g);
          chk("one_in_flight", q.size(), 0);
          if (g >= 0) begin
            o.a = snap_a[16*g +: 16];
            o.b = snap_b[16*g +: 16];
            o.cm = snap_cm[2*g +: 2];
            o.id = g;
            o.e = o.cm == 2'b11 || stall_mul;
            o.d = o.e ? 32'd0 : mul_ref(o.a, o.b, o.cm);
            q.push_back(o);
            glog.push_back(g);
            mptr = (g + 1) % NR;
          end
        end
        if (mul_enable_o) begin
          en_cycles++;
          if (q.size() == 0) chk("enable_without_op", 32'(mul_enable_o), 0);
          else begin
            chk("mul_a", mul_a_o, q[0].a);
            chk("mul_b", mul_b_o, q[0].b);
            chk("mul_cm", mul_cm_o, q[0].cm);
            chk("enable_on_illegal", 32'(q[0].cm == 2'b11), 0);
          end
        end
        if (rsp_valid_o) begin
          if (q.size() == 0) chk("spurious_rsp", 32'(rsp_valid_o), 0);
          else begin
            chk("rsp_data", rsp_data_o, q[0].d);
            chk("rsp_id", rsp_id_o, q[0].id);
            chk("rsp_err", rsp_err_o, q[0].e);
            if (rsp_ready_i) begin
              last_d = rsp_data_o;
              last_id = rsp_id_o;
              last_e = rsp_err_o;
              n_rsp++;
              void'(q.pop_front());
            end
          end
        end
        if (q.size() != 0) chk("busy", busy_o, 1);
      end
      prev_rst = reset_i;
      snap_v = req_valid_i;
      snap_a = req_a_i;
      snap_b = req_b_i;
      snap_cm = req_cm_i;
    end
  end

  task automatic new_payload(input int k, input bit legal);
    req_a_i[16*k +: 16] = 16'($urandom);
    req_b_i[16*k +: 16] = 16'($urandom);
    req_cm_i[2*k +: 2] = (!legal && $urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
  endtask

  task automatic tick();
    @(posedge clk); #1;
    for (int k = 0; k < NR; k++) begin
      if (req_ready_o[k]) begin
        if (mode == 1) new_payload(k, 1);
        else req_valid_i[k] = 0;
      end else if (mode == 2) begin
        if (!req_valid_i[k] && $urandom_range(0, 3) == 0) begin
          new_payload(k, 0);
          req_valid_i[k] = 1;
        end else if (req_valid_i[k] && $urandom_range(0, 15) == 0) req_valid_i[k] = 0;
      end
    end
    if (mode == 2) rsp_ready_i = $urandom_range(0, 9) < 7;
  endtask

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b, input logic [1:0] cm);
    req_a_i[16*k +: 16] = a;
    req_b_i[16*k +: 16] = b;
    req_cm_i[2*k +: 2] = cm;
    req_valid_i[k] = 1;
  endtask

  task automatic drain();
    mode = 0;
    rsp_ready_i = 1;
    req_valid_i = '0;
    for (int i = 0; i < 500 && (busy_o || q.size() != 0); i++) tick();
    chk("drain_idle", busy_o, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 0);
    chk({tag, "_enable"}, mul_enable_o, 0);
    chk({tag, "_mul_cm"}, mul_cm_o, 0);
    chk({tag, "_mul_a"}, mul_a_o, 0);
    chk({tag, "_mul_b"}, mul_b_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_rsp_id"}, rsp_id_o, 0);
    chk({tag, "_rsp_err"}, rsp_err_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic run_one(input int k, input logic [15:0] a, input logic [15:0] b, input logic [1:0] cm,
                         input logic [31:0] ed, input logic ee, input string tag);
    int n0;
    n0 = n_rsp;
    set_req(k, a, b, cm);
    for (int i = 0; i < 300 && n_rsp == n0; i++) tick();
    chk({tag, "_done"}, 32'(n_rsp != n0), 1);
    chk({tag, "_data"}, last_d, ed);
    chk({tag, "_id"}, last_id, k);
    chk({tag, "_err"}, last_e, ee);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, en0;
    repeat (3) tick();
    chk_zero("reset");
    reset_i = 0;
    tick();
    // continuous requests from everyone: strict rotation from pointer 0
    glog.delete();
    for (int k = 0; k < NR; k++) begin
      new_payload(k, 1);
      req_valid_i[k] = 1;
    end
    mode = 1;
    for (int i = 0; i < 400 && glog.size() < 5; i++) tick();
    chk("order_count", 32'(glog.size() >= 5), 1);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk($sformatf("order_%0d", i), glog[i], exp_order[i]);
    drain();
    run_one(1, 16'h0003, 16'hFFFE, 2'b10, 32'hFFFFFFFA, 0, "m16");
    run_one(0, 16'h0203, 16'h0405, 2'b01, 32'h0008000F, 0, "m2x8");
    run_one(3, 16'h00FF, 16'h0002, 2'b00, 32'hFFFFFFFE, 0, "m8");
    en0 = en_cycles;
    run_one(2, 16'h1111, 16'h2222, 2'b11, 32'h0, 1, "ill");
    chk("ill_no_enable", en_cycles - en0, 0);
    drain();
    n0 = n_rsp;
    mode = 2;
    repeat (3000) tick();
    drain();
    chk("random_progress", 32'(n_rsp - n0 >= 100), 1);
    // stalled response, then reset in the middle of the following operation
    rsp_ready_i = 0;
    set_req(1, 16'h1234, 16'h0002, 2'b10);
    for (int i = 0; i < 100 && !rsp_valid_o; i++) tick();
    chk("stall_rsp_seen", rsp_valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_hold", rsp_valid_o, 1);
    end
    n0 = n_rsp;
    rsp_ready_i = 1;
    for (int i = 0; i < 20 && n_rsp == n0; i++) tick();
    chk("stall_done", 32'(n_rsp != n0), 1);
    chk("stall_data", last_d, 32'h00002468);
    set_req(3, 16'h0100, 16'h0100, 2'b10);
    for (int i = 0; i < 100 && !mul_enable_o; i++) tick();
    chk("pre_reset_enable", mul_enable_o, 1);
    reset_i = 1;
    tick();
    reset_i = 0;
    chk_zero("mid_reset");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("no_rsp_after_reset", rsp_valid_o, 0);
    end
    run_one(0, 16'h0003, 16'hFFFE, 2'b10, 32'hFFFFFFFA, 0, "post_reset");
`ifdef CMS_TIMEOUT_EN
    drain();
    stall_mul = 1;
    en0 = en_cycles;
    run_one(0, 16'h0005, 16'h0007, 2'b10, 32'h0, 1, "timeout");
    chk("timeout_cycles", en_cycles - en0, 64);
    stall_mul = 0;
`endif
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
